// File: rtl/trap_ctrl.sv
// Machine-mode trap entry/exit sequencer; exception ack->redirect 4 cycles, mret 3; busy_o stalls the pipeline.
// Optional VECTORED_MODE_EN enables vectored interrupt dispatch (direct dispatch when undefined).
module trap_ctrl #(
  parameter int unsigned IRQ_VEC_LIMIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exc_req_i,
  input  logic [31:0] exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  output logic        exc_ack_o,
  output logic        busy_o,
  output logic [31:0] csr_addr_o,
  output logic        csr_we_o,
  output logic        csr_re_o,
  output logic [31:0] csr_wdata_o,
  output logic        csr_except_o,
  input  logic [31:0] csr_rdata_i,
  input  logic [31:0] mtvec_i,
  output logic        pc_redirect_o,
  output logic [31:0] pc_target_o
);

  typedef enum logic [2:0] {
    IDLE, SAVE_EPC, SAVE_CAUSE, LOAD_VEC, MRET_RD, MRET_WAIT, REDIRECT
  } state_t;

  localparam logic [31:0] MEPC_ADDR   = 32'h0000_0341;
  localparam logic [31:0] MCAUSE_ADDR = 32'h0000_0342;
  localparam logic [31:0] ALIGN_MASK  = 32'hFFFF_FFFC;

`ifdef VECTORED_MODE_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] target_q;

  logic [31:0] base;
  logic [31:0] vec_target;
  logic        vec_hit;

  // Offset is cause<<2 truncated to 32 bits, so the sum wraps silently.
  assign base       = mtvec_i & ALIGN_MASK;
  assign vec_target = base + {cause_q[29:0], 2'b00};
  assign vec_hit    = VEC_EN && (mtvec_i[1:0] == 2'b01) && cause_q[31] &&
                      ({1'b0, cause_q[30:0]} < 32'(IRQ_VEC_LIMIT));

  assign exc_ack_o   = (state == IDLE) && (exc_req_i || mret_i);
  assign pc_target_o = target_q;

  // CSR-side outputs are registered with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      pc_q          <= '0;
      cause_q       <= '0;
      target_q      <= '0;
      busy_o        <= 1'b0;
      csr_addr_o    <= '0;
      csr_we_o      <= 1'b0;
      csr_re_o      <= 1'b0;
      csr_wdata_o   <= '0;
      csr_except_o  <= 1'b0;
      pc_redirect_o <= 1'b0;
    end else begin
      busy_o        <= 1'b1;
      csr_addr_o    <= '0;
      csr_we_o      <= 1'b0;
      csr_re_o      <= 1'b0;
      csr_wdata_o   <= '0;
      csr_except_o  <= 1'b0;
      pc_redirect_o <= 1'b0;
      case (state)
        IDLE: begin
          if (exc_req_i) begin
            pc_q        <= exc_pc_i;
            cause_q     <= exc_cause_i;
            state       <= SAVE_EPC;
            csr_addr_o  <= MEPC_ADDR;
            csr_we_o    <= 1'b1;
            csr_wdata_o <= exc_pc_i;
          end else if (mret_i) begin
            state      <= MRET_RD;
            csr_addr_o <= MEPC_ADDR;
            csr_re_o   <= 1'b1;
          end else begin
            busy_o <= 1'b0;
          end
        end
        SAVE_EPC: begin
          state        <= SAVE_CAUSE;
          csr_addr_o   <= MCAUSE_ADDR;
          csr_we_o     <= 1'b1;
          csr_wdata_o  <= cause_q;
          csr_except_o <= 1'b1;
        end
        SAVE_CAUSE: begin
          state        <= LOAD_VEC;
          csr_except_o <= 1'b1;
        end
        LOAD_VEC: begin
          target_q      <= vec_hit ? vec_target : base;
          state         <= REDIRECT;
          pc_redirect_o <= 1'b1;
        end
        MRET_RD: begin
          state <= MRET_WAIT;
        end
        MRET_WAIT: begin
          target_q      <= csr_rdata_i & ALIGN_MASK;
          state         <= REDIRECT;
          pc_redirect_o <= 1'b1;
        end
        REDIRECT: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: vector table, hand-written corner sequences, randomized model check.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        exc_req_i = 1'b0;
  logic [31:0] exc_cause_i = '0;
  logic [31:0] exc_pc_i = '0;
  logic        mret_i = 1'b0;
  logic        exc_ack_o;
  logic        busy_o;
  logic [31:0] csr_addr_o;
  logic        csr_we_o;
  logic        csr_re_o;
  logic [31:0] csr_wdata_o;
  logic        csr_except_o;
  logic [31:0] csr_rdata_i = '0;
  logic [31:0] mtvec_i = '0;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.IRQ_VEC_LIMIT(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .exc_req_i(exc_req_i), .exc_cause_i(exc_cause_i),
    .exc_pc_i(exc_pc_i), .mret_i(mret_i), .exc_ack_o(exc_ack_o), .busy_o(busy_o),
    .csr_addr_o(csr_addr_o), .csr_we_o(csr_we_o), .csr_re_o(csr_re_o),
    .csr_wdata_o(csr_wdata_o), .csr_except_o(csr_except_o), .csr_rdata_i(csr_rdata_i),
    .mtvec_i(mtvec_i), .pc_redirect_o(pc_redirect_o), .pc_target_o(pc_target_o)
  );

  always #5 clk_i = ~clk_i;

  // Minimal CSR file: mepc writes rejected in except mode, reads registered.
  logic [31:0] f_mepc = '0;
  logic [31:0] f_mcause = '0;
  always @(posedge clk_i) begin
    if (csr_we_o && !csr_except_o && csr_addr_o == 32'h341) f_mepc <= csr_wdata_o;
    if (csr_we_o && csr_addr_o == 32'h342) f_mcause <= csr_wdata_o;
    if (csr_re_o && csr_addr_o == 32'h341) csr_rdata_i <= f_mepc;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_tgt(input logic [31:0] mtvec, input logic [31:0] cause);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
`ifdef VECTORED_MODE_EN
    if (mtvec[1:0] == 2'b01 && cause[31] && cause[30:0] < 31'd16)
      return base + cause[30:0] * 4;
`endif
    return base;
  endfunction

  // Observation log filled by mon
  logic [31:0] w_addr[4], w_dat[4], r_addr;
  logic        w_exc[4], r_exc, exc_hist[9];
  int          nw, nr;

  task automatic mon(input int pulse_at, output int lat, output logic [31:0] tgt,
                     output bit ack_seen);
    lat = 0; tgt = 'x; ack_seen = 0; nw = 0; nr = 0; r_addr = 'x; r_exc = 1'bx;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk_i);
      exc_hist[cyc] = csr_except_o;
      if (csr_we_o && nw < 4) begin
        w_addr[nw] = csr_addr_o; w_dat[nw] = csr_wdata_o; w_exc[nw] = csr_except_o; nw++;
      end
      if (csr_re_o) begin r_addr = csr_addr_o; r_exc = csr_except_o; nr++; end
      if (exc_ack_o) ack_seen = 1;
      exc_req_i = (cyc == pulse_at);
      if (pc_redirect_o) begin lat = cyc; tgt = pc_target_o; break; end
    end
    exc_req_i = 1'b0;
  endtask

  task automatic txn(input bit m, input logic [31:0] pc, input logic [31:0] cause,
                     input logic [31:0] mtvec, input logic [31:0] exp_tgt, input string nm);
    int lat; logic [31:0] tgt; bit ack_seen;
    @(posedge clk_i); #1;
    mtvec_i = mtvec;
    if (m) mret_i = 1'b1;
    else begin exc_req_i = 1'b1; exc_pc_i = pc; exc_cause_i = cause; end
    @(negedge clk_i);
    chk({nm, "_ack"}, 32'(exc_ack_o), 32'd1);
    @(posedge clk_i); #1;
    exc_req_i = 1'b0; mret_i = 1'b0; exc_pc_i = $urandom; exc_cause_i = $urandom;
    mon(0, lat, tgt, ack_seen);
    chk({nm, "_lat"}, 32'(lat), m ? 32'd3 : 32'd4);
    chk({nm, "_tgt"}, tgt, exp_tgt);
    if (m) begin
      chk({nm, "_nwr"}, 32'(nw), 32'd0);
      chk({nm, "_nrd"}, 32'(nr), 32'd1);
      chk({nm, "_rd_addr"}, r_addr, 32'h341);
      chk({nm, "_rd_exc"}, 32'(r_exc), 32'd0);
    end else begin
      chk({nm, "_nwr"}, 32'(nw), 32'd2);
      chk({nm, "_wr0"}, {w_addr[0], w_dat[0]} == {32'h341, pc} ? 32'd1 : 32'd0, 32'd1);
      chk({nm, "_wr0_exc"}, 32'(w_exc[0]), 32'd0);
      chk({nm, "_wr1"}, {w_addr[1], w_dat[1]} == {32'h342, cause} ? 32'd1 : 32'd0, 32'd1);
      chk({nm, "_wr1_exc"}, 32'(w_exc[1]), 32'd1);
      chk({nm, "_vec_exc"}, 32'(exc_hist[3]), 32'd1);
      chk({nm, "_mcause"}, f_mcause, cause);
    end
    @(negedge clk_i);
    chk({nm, "_idle"}, {31'd0, busy_o | pc_redirect_o}, 32'd0);
    chk({nm, "_hold"}, pc_target_o, exp_tgt);
  endtask

  typedef struct {
    bit          m;
    logic [31:0] pc, cause, mtvec, tgt;
  } vec_t;

  function automatic vec_t mk(input bit m, input logic [31:0] pc, input logic [31:0] cause,
                              input logic [31:0] mtvec, input logic [31:0] tgt);
    vec_t v; v.m = m; v.pc = pc; v.cause = cause; v.mtvec = mtvec; v.tgt = tgt;
    return v;
  endfunction

`ifdef VECTORED_MODE_EN
  localparam bit VEC = 1'b1;
`else
  localparam bit VEC = 1'b0;
`endif

  initial begin
    vec_t tbl[11];
    int lat; logic [31:0] tgt, last_pc; bit ack_seen;

    tbl[0]  = mk(0, 32'h0000_0204, 32'h0000_0002, 32'h0000_1000, 32'h0000_1000);
    tbl[1]  = mk(1, 32'h0, 32'h0, 32'h0000_1000, 32'h0000_0204);
    tbl[2]  = mk(0, 32'h0000_0207, 32'h0000_0002, 32'h0000_1000, 32'h0000_1000);
    tbl[3]  = mk(1, 32'h0, 32'h0, 32'h0000_1000, 32'h0000_0204);
    tbl[4]  = mk(0, 32'h0000_0300, 32'h8000_0007, 32'h0000_2001, VEC ? 32'h0000_201C : 32'h0000_2000);
    tbl[5]  = mk(0, 32'h0000_0304, 32'h8000_0010, 32'h0000_2001, 32'h0000_2000);
    tbl[6]  = mk(0, 32'h0000_0308, 32'h8000_000F, 32'h0000_2001, VEC ? 32'h0000_203C : 32'h0000_2000);
    tbl[7]  = mk(0, 32'h0000_030C, 32'h0000_0007, 32'h0000_2001, 32'h0000_2000);
    tbl[8]  = mk(0, 32'h0000_0310, 32'h8000_0001, 32'h0000_2002, 32'h0000_2000);
    tbl[9]  = mk(0, 32'h0000_1237, 32'h8000_0005, 32'hFFFF_FFF1, VEC ? 32'h0000_0004 : 32'hFFFF_FFF0);
    tbl[10] = mk(1, 32'h0, 32'h0, 32'h0, 32'h0000_1234);

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_csr", {csr_addr_o | csr_wdata_o} | {27'd0, csr_we_o, csr_re_o, csr_except_o, pc_redirect_o, exc_ack_o}, 32'd0);
    chk("rst_tgt", pc_target_o, 32'd0);
    rst_ni = 1'b1;

    foreach (tbl[i]) txn(tbl[i].m, tbl[i].pc, tbl[i].cause, tbl[i].mtvec, tbl[i].tgt, $sformatf("vec%0d", i));

    // Simultaneous requests, held mret, exception pulsed while busy.
    @(posedge clk_i); #1;
    mtvec_i = 32'h0000_1000; exc_req_i = 1'b1; exc_pc_i = 32'h0000_0500; exc_cause_i = 32'h4; mret_i = 1'b1;
    @(negedge clk_i);
    chk("both_ack", 32'(exc_ack_o), 32'd1);
    @(posedge clk_i); #1;
    exc_req_i = 1'b0;
    mon(2, lat, tgt, ack_seen);
    chk("both_lat", 32'(lat), 32'd4);
    chk("both_tgt", tgt, 32'h0000_1000);
    chk("both_no_busy_ack", 32'(ack_seen), 32'd0);
    @(negedge clk_i);
    chk("held_mret_ack", 32'(exc_ack_o), 32'd1);
    @(posedge clk_i); #1;
    mret_i = 1'b0;
    mon(1, lat, tgt, ack_seen);
    chk("held_mret_lat", 32'(lat), 32'd3);
    chk("held_mret_tgt", tgt, 32'h0000_0500);
    chk("pulse_no_ack", 32'(ack_seen), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("pulse_no_seq", 32'(busy_o), 32'd0);

    // Reset asserted during SAVE_CAUSE.
    @(posedge clk_i); #1;
    exc_req_i = 1'b1; exc_pc_i = 32'h0000_0404; exc_cause_i = 32'h3;
    @(posedge clk_i); #1;
    exc_req_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("mid_state_cause_wr", {31'd0, csr_we_o & csr_except_o}, 32'd1);
    rst_ni = 1'b0; #1;
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_csr", {csr_addr_o | csr_wdata_o} | {28'd0, csr_we_o, csr_re_o, csr_except_o, pc_redirect_o}, 32'd0);
    chk("mid_rst_tgt", pc_target_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mon(0, lat, tgt, ack_seen);
    chk("mid_rst_no_redirect", 32'(lat), 32'd0);
    chk("mid_rst_mepc_kept", f_mepc, 32'h0000_0404);
    last_pc = 32'h0000_0404;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] mt, c, p;
      bit m;
      m = ($urandom_range(0, 3) == 0);
      mt = $urandom;
      if ($urandom_range(0, 1) == 1) mt[1:0] = 2'b01;
      c = 32'($urandom_range(0, 24));
      c[31] = 1'($urandom_range(0, 1));
      p = $urandom;
      if (m) txn(1, p, c, mt, {last_pc[31:2], 2'b00}, $sformatf("rnd%0d", n));
      else begin
        txn(0, p, c, mt, ref_tgt(mt, c), $sformatf("rnd%0d", n));
        last_pc = p;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Machine-mode trap sequencer that sits directly upstream of the CSR register file.
- On an exception it saves the faulting PC to mepc (0x341) and the cause to mcause (0x342), then reads mtvec through the file's mtvec output and redirects fetch to the handler.
- On mret it reads mepc back and redirects fetch to it.
- It is the sole driver of the CSR file's address, enable, write-data and except inputs during trap entry and exit.

Parameters:
IRQ_VEC_LIMIT, 16, vectored dispatch only applies when cause[30:0] < IRQ_VEC_LIMIT; otherwise the handler base is used.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
exc_req_i  in  1  exception/interrupt request from pipeline (level)
exc_cause_i  in  32  cause; bit31=interrupt
exc_pc_i  in  32  PC to save in mepc
mret_i  in  1  mret request from pipeline (level)
exc_ack_o  out  1  request accepted this cycle
busy_o  out  1  sequencer not idle; pipeline must stall
csr_addr_o  out  32  CSR address to file
csr_we_o  out  1  CSR write enable
csr_re_o  out  1  CSR read enable
csr_wdata_o  out  32  CSR write data
csr_except_o  out  1  except-mode pin to file
csr_rdata_i  in  32  file read data (registered, valid 1 cycle after read)
mtvec_i  in  32  file mtvec output (registered while except=1)
pc_redirect_o  out  1  one-cycle fetch redirect pulse
pc_target_o  out  32  redirect target, valid when pc_redirect_o=1

Behaviour:
- Reset (rst_ni=0, async): state=IDLE; latched pc/cause/target=0.
- In IDLE all outputs are 0, except exc_ack_o (combinational) and pc_target_o (holds the last target, 0 after reset).
- FSM states: IDLE, SAVE_EPC, SAVE_CAUSE, LOAD_VEC, MRET_RD, MRET_WAIT, REDIRECT.
- IDLE:
  - If exc_req_i=1: exc_ack_o=1 (combinational), latch exc_pc_i and exc_cause_i, go to SAVE_EPC.
  - Else if mret_i=1: exc_ack_o=1, go to MRET_RD.
  - Exception wins when both are asserted; the mret is not acked and the pipeline must hold it.
- Requests are sampled only in IDLE. exc_req_i and mret_i are ignored while busy_o=1; the pipeline holds them.
- SAVE_EPC: addr=0x341, we=1, wdata=latched pc, except=0 (the file rejects mepc writes in except mode). Next: SAVE_CAUSE.
- SAVE_CAUSE: addr=0x342, we=1, wdata=latched cause, except=1. The file updates mtvec_o at the end of this cycle. Next: LOAD_VEC.
- LOAD_VEC: except=1, no we/re. Sample mtvec_i and compute the target:
  - base = {mtvec_i[31:2],2'b00}.
  - If mtvec_i[1:0]=01, cause[31]=1 and cause[30:0]<IRQ_VEC_LIMIT: target = base + (cause[30:0]<<2), mod 2^32 (wrap silently).
  - Otherwise target = base. mode 10/11 are treated as direct.
  - Register the target. Next: REDIRECT.
- MRET_RD: addr=0x341, re=1, except=0. Next: MRET_WAIT.
- MRET_WAIT: sample csr_rdata_i; target={rdata[31:2],2'b00}. Next: REDIRECT.
- REDIRECT: pc_redirect_o=1 for exactly one cycle. Next: IDLE.
- busy_o=1 in every state except IDLE.
- Latency from ack to redirect pulse: exception 4 cycles; mret 3 cycles.
- Back-to-back: a request present in the IDLE cycle after REDIRECT is accepted immediately.
- Reset mid-sequence: immediate return to IDLE; no redirect is issued; a partially written CSR stays written.
- csr_addr_o, csr_we_o, csr_re_o, csr_wdata_o and csr_except_o are decoded from registered state: glitch-free, never X after reset.

Optional Feature:
VECTORED_MODE_EN.
- Defined: vectored dispatch as described above.
- Undefined: mtvec_i[1:0] is ignored, target=base always, and IRQ_VEC_LIMIT is unused.

Test Plan:
- Reset: rst_ni=0 mid-SAVE_CAUSE, then release -> busy_o=0, all CSR outputs 0, no pc_redirect_o pulse.
- Sync exception, direct mode: mtvec=0x0000_1000, exc_req_i with pc=0x0000_0204, cause=0x2 -> writes 0x341<=0x204 (except=0), then 0x342<=0x2 (except=1), then pc_redirect_o on cycle 4 with target 0x0000_1000.
- Vectored interrupt (VECTORED_MODE_EN defined): mtvec=0x0000_2001, cause=0x8000_0007 -> target 0x0000_201C. Same stimulus with the macro undefined -> target 0x0000_2000.
- Cause at or above limit: cause=0x8000_0010, IRQ_VEC_LIMIT=16, mtvec=0x0000_2001 -> target 0x0000_2000.
- mret: mepc=0x0000_0207 -> read of 0x341 with except=0, then redirect 3 cycles after ack with target 0x0000_0204.
- Simultaneous and held requests: exc_req_i and mret_i both high in IDLE -> exception acked, mret not acked. mret still held after REDIRECT -> acked in the next IDLE cycle; exc_req_i pulsed while busy -> no second ack.
